// File: rtl/lif_core_array.sv
// Time-multiplexed LIF neuron array: one shared leak/integrate/fire datapath visits every neuron once per step.
// Optional refractory counters are built when LIF_REFRACTORY_EN is defined.
module lif_core_array #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned REFR_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         step_start,
    input  logic [N_NEURONS*WIDTH-1:0]   current,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [3:0]                   leak_shift,
    input  logic [REFR_W-1:0]            refr_cycles,
    input  logic [$clog2(N_NEURONS)-1:0] mon_sel,
    output logic                         busy,
    output logic                         step_done,
    output logic [N_NEURONS-1:0]         spikes,
    output logic [WIDTH-1:0]             mon_v
);

    localparam int unsigned     IDX_W    = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [WIDTH-1:0] V_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic                   accept, upd;
    logic                   busy_nxt, done_nxt;

    logic [WIDTH-1:0]       cur_q [N_NEURONS];
    logic [WIDTH-1:0]       th_q;
    logic [3:0]             ls_q;
    logic [WIDTH-1:0]       v_q [N_NEURONS];
    logic [N_NEURONS-1:0]   shadow, shadow_nxt;

    logic [WIDTH-1:0]       v_cur, leak, v_sat, v_new, mon_nxt;
    logic [WIDTH:0]         sum;
    logic                   fire, spike;

`ifdef LIF_REFRACTORY_EN
    logic [REFR_W-1:0]      refr_lat;
    logic [REFR_W-1:0]      refr_q [N_NEURONS];
    logic [REFR_W-1:0]      refr_new;
`else
    logic                   unused_refr;
    assign unused_refr = ^refr_cycles;
`endif

    // State register and step sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            busy      <= busy_nxt;
            step_done <= done_nxt;
        end
    end

    // Next-state logic; requests outside IDLE are dropped
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        upd       = 1'b0;
        case (state)
            S_IDLE: begin
                if (step_start) begin
                    state_nxt = S_UPDATE;
                    idx_nxt   = '0;
                    accept    = 1'b1;
                end
            end
            S_UPDATE: begin
                upd = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    // Per-neuron update at WIDTH+1 bits: leak, integrate, saturate, fire
    always_comb begin
        v_cur      = v_q[idx];
        leak       = (32'(ls_q) >= WIDTH) ? '0 : (v_cur >> ls_q);
        sum        = {1'b0, v_cur} - {1'b0, leak} + {1'b0, cur_q[idx]};
        v_sat      = sum[WIDTH] ? V_MAX : sum[WIDTH-1:0];
        fire       = (v_sat >= th_q);
        spike      = 1'b0;
        v_new      = v_sat;
`ifdef LIF_REFRACTORY_EN
        refr_new   = refr_q[idx];
        if (refr_q[idx] != '0) begin
            v_new    = '0;
            refr_new = refr_q[idx] - 1'b1;
        end else if (fire) begin
            spike    = 1'b1;
            v_new    = '0;
            refr_new = refr_lat;
        end
`else
        if (fire) begin
            spike = 1'b1;
            v_new = '0;
        end
`endif
        shadow_nxt      = shadow;
        shadow_nxt[idx] = spike;
    end

    // Parameter latch, membrane file and spike vectors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_q   <= '0;
            ls_q   <= '0;
            shadow <= '0;
            spikes <= '0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                cur_q[i] <= '0;
                v_q[i]   <= '0;
            end
        end else begin
            if (accept) begin
                th_q <= threshold;
                ls_q <= leak_shift;
                for (int unsigned i = 0; i < N_NEURONS; i++) begin
                    cur_q[i] <= current[i*WIDTH +: WIDTH];
                end
            end
            if (upd) begin
                v_q[idx] <= v_new;
                shadow   <= shadow_nxt;
                if (idx == LAST_IDX) begin
                    spikes <= shadow_nxt;
                end
            end
        end
    end

`ifdef LIF_REFRACTORY_EN
    // Refractory counters, loaded on a spike and counted down on later steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refr_lat <= '0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                refr_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                refr_lat <= refr_cycles;
            end
            if (upd) begin
                refr_q[idx] <= refr_new;
            end
        end
    end
`endif

    // Monitor mux; indices beyond the array read as zero
    always_comb begin
        mon_nxt = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            if (mon_sel == IDX_W'(i)) begin
                mon_nxt = v_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_v <= '0;
        end else begin
            mon_v <= mon_nxt;
        end
    end

endmodule

// File: tb/tb_lif_core_array.sv
// Randomised and directed bench for lif_core_array against a per-step arithmetic neuron model.
module tb_lif_core_array;

    localparam int N = 4;
    localparam int W = 8;
    localparam int R = 3;
    localparam int VMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           step_start;
    logic [N*W-1:0] current;
    logic [W-1:0]   threshold;
    logic [3:0]     leak_shift;
    logic [R-1:0]   refr_cycles;
    logic [1:0]     mon_sel;
    logic           busy;
    logic           step_done;
    logic [N-1:0]   spikes;
    logic [W-1:0]   mon_v;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int           v_m [N];
    int           r_m [N];
    logic [N-1:0] spk_m;

    lif_core_array #(.N_NEURONS(N), .WIDTH(W), .REFR_W(R)) dut (
        .clk(clk), .rst_n(rst_n), .step_start(step_start), .current(current),
        .threshold(threshold), .leak_shift(leak_shift), .refr_cycles(refr_cycles),
        .mon_sel(mon_sel), .busy(busy), .step_done(step_done), .spikes(spikes),
        .mon_v(mon_v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            v_m[i] = 0;
            r_m[i] = 0;
        end
        spk_m = '0;
    endfunction

    // One whole time-step of every neuron, straight from the update rule
    function automatic void model_step(input logic [N*W-1:0] cur, input int th, input int ls, input int rc);
        int in_i, nv;
        for (int i = 0; i < N; i++) begin
            in_i     = int'(cur[i*W +: W]);
            spk_m[i] = 1'b0;
`ifdef LIF_REFRACTORY_EN
            if (r_m[i] != 0) begin
                v_m[i] = 0;
                r_m[i] = r_m[i] - 1;
                continue;
            end
`endif
            nv = v_m[i] - ((ls >= W) ? 0 : (v_m[i] >> ls)) + in_i;
            if (nv > VMAX) nv = VMAX;
            if (nv >= th) begin
                spk_m[i] = 1'b1;
                v_m[i]   = 0;
                r_m[i]   = rc;
            end else begin
                v_m[i] = nv;
            end
        end
    endfunction

    function automatic logic [N*W-1:0] rand_cur(input int maxv);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom_range(0, maxv));
        return r;
    endfunction

    function automatic logic [N*W-1:0] one_cur(input int n, input int val);
        logic [N*W-1:0] r;
        r = '0;
        r[n*W +: W] = W'(val);
        return r;
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        step_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one step, scramble inputs mid-step, then compare timing, spikes and every membrane
    task automatic run_step(input logic [N*W-1:0] cur, input logic [W-1:0] th,
                            input logic [3:0] ls, input logic [R-1:0] rc);
        int lat;
        bit seen;
        @(negedge clk);
        current = cur; threshold = th; leak_shift = ls; refr_cycles = rc;
        step_start = 1'b1;
        @(posedge clk);
        #1;
        step_start  = 1'b0;
        current     = rand_cur(VMAX);
        threshold   = W'($urandom);
        leak_shift  = 4'($urandom);
        refr_cycles = R'($urandom);
        model_step(cur, int'(th), int'(ls), int'(rc));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (step_done) seen = 1'b1;
        end
        checks++;
        if (lat !== N) begin
            errors++;
            $display("FAIL step_latency got %0d exp %0d", lat, N);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_done got %b exp 1", busy);
        end
        checks++;
        if (spikes !== spk_m) begin
            errors++;
            $display("FAIL spikes got %b exp %b", spikes, spk_m);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || step_done !== 1'b0) begin
            errors++;
            $display("FAIL after_done busy=%b done=%b exp 0 0", busy, step_done);
        end
        for (int i = 0; i < N; i++) begin
            mon_sel = 2'(i);
            @(posedge clk);
            #1;
            checks++;
            if (mon_v !== W'(v_m[i])) begin
                errors++;
                $display("FAIL v[%0d] got %0d exp %0d", i, mon_v, v_m[i]);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || step_done !== 1'b0 || spikes !== '0 || mon_v !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b spikes=%b mon_v=%0d exp all 0",
                     busy, step_done, spikes, mon_v);
        end
    endtask

    task automatic test_integrate();
        int exp_v0 [4] = '{30, 60, 90, 0};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            run_step(one_cur(0, 30), W'(100), 4'd8, R'(0));
            mon_sel = 2'd0;
            @(posedge clk);
            #1;
            checks++;
            if (mon_v !== W'(exp_v0[k]) || spikes !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL integrate_step%0d v0=%0d spikes=%b exp v0=%0d", k, mon_v, spikes, exp_v0[k]);
            end
        end
    endtask

    task automatic test_leak();
        apply_reset();
        for (int k = 0; k < 8; k++) run_step(one_cur(1, 64), W'(255), 4'd1, R'(0));
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 2; k++) run_step(one_cur(2, 200), W'(255), 4'd8, R'(0));
    endtask

    task automatic test_refractory();
        apply_reset();
        for (int k = 0; k < 4; k++) run_step(one_cur(3, 20), W'(10), 4'd8, R'(2));
    endtask

    task automatic test_threshold_zero();
        apply_reset();
        run_step(rand_cur(40), W'(0), 4'd2, R'(0));
        run_step('0, W'(0), 4'd0, R'(0));
    endtask

    task automatic test_handshake();
        logic [N*W-1:0] cur;
        int dones, n, guard;
        int t [3];
        apply_reset();
        cur = rand_cur(50);
        @(negedge clk);
        current = cur; threshold = W'(120); leak_shift = 4'd3; refr_cycles = R'(1);
        step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        model_step(cur, 120, 3, 1);
        repeat (2) @(posedge clk);
        #1 step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (step_done) dones++;
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignored_start done_count got %0d exp 1", dones);
        end
        checks++;
        if (spikes !== spk_m) begin
            errors++;
            $display("FAIL ignored_start spikes got %b exp %b", spikes, spk_m);
        end
        // held-high request: back-to-back steps every N+2 cycles
        @(negedge clk);
        step_start = 1'b1;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 40) begin
            @(posedge clk);
            guard++;
            #1;
            if (step_done) begin
                t[n] = cyc;
                n++;
                if (n == 3) step_start = 1'b0;
            end
        end
        step_start = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL back_to_back done_count got %0d exp 3", n);
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (t[k] - t[k-1] !== N + 2) begin
                    errors++;
                    $display("FAIL back_to_back period got %0d exp %0d", t[k] - t[k-1], N + 2);
                end
            end
        end
        for (int k = 0; k < 3; k++) model_step(cur, 120, 3, 1);
        repeat (3) @(posedge clk);
        for (int i = 0; i < N; i++) begin
            mon_sel = 2'(i);
            @(posedge clk);
            #1;
            checks++;
            if (mon_v !== W'(v_m[i])) begin
                errors++;
                $display("FAIL back_to_back v[%0d] got %0d exp %0d", i, mon_v, v_m[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        apply_reset();
        run_step({4{8'd50}}, W'(0), 4'd8, R'(0));
        @(negedge clk);
        current = {4{8'd40}}; threshold = W'(200); leak_shift = 4'd8; refr_cycles = R'(0);
        mon_sel = 2'd1;
        step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || spikes !== '0 || mon_v !== '0 || step_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%b spikes=%b mon_v=%0d done=%b exp all 0",
                     busy, spikes, mon_v, step_done);
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (step_done) done_seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (8) begin
            @(posedge clk);
            #1;
            if (step_done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset step_done got 1 exp 0");
        end
        for (int i = 0; i < N; i++) begin
            mon_sel = 2'(i);
            @(posedge clk);
            #1;
            checks++;
            if (mon_v !== '0) begin
                errors++;
                $display("FAIL mid_reset v[%0d] got %0d exp 0", i, mon_v);
            end
        end
        run_step(one_cur(0, 30), W'(100), 4'd8, R'(0));
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            run_step(rand_cur(($urandom_range(0, 1) == 0) ? 60 : VMAX),
                     W'($urandom_range(0, VMAX)), 4'($urandom_range(0, 9)),
                     R'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        step_start  = 1'b0;
        current     = '0;
        threshold   = '0;
        leak_shift  = '0;
        refr_cycles = '0;
        mon_sel     = '0;
        apply_reset();
        test_reset();
        test_integrate();
        test_leak();
        test_saturation();
        test_refractory();
        test_threshold_zero();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
